// File: rtl/ddr_traffic_chk.sv
`default_nettype none
// ============================================================================
// Module   : ddr_traffic_chk
// Brief    : MIG 7-series app-interface pattern writer / read-back checker.
// Revision : 1.0 - initial release
// ============================================================================
module ddr_traffic_chk #(
    parameter int          ADDR_W     = 29,
    parameter int          DATA_W     = 256,
    parameter int          BURST_NUM  = 20,
    parameter int          ADDR_STEP  = 8,
    parameter int          START_ADDR = 0,
    parameter logic [31:0] SEED       = 32'h0,
    parameter int          DATA_INC   = 2,
    parameter int          LOOP       = 0,
    parameter int          ERR_W      = 16,
    parameter int          RD_TIMEOUT = 1024
) (
    input  logic                ui_clk,
    input  logic                sys_rst,
    input  logic                init_calib_complete,
    input  logic                start,
    input  logic                stop,
    input  logic                app_rdy,
    input  logic                app_wdf_rdy,
    input  logic [DATA_W-1:0]   app_rd_data,
    input  logic                app_rd_data_valid,
    output logic [ADDR_W-1:0]   app_addr,
    output logic [2:0]          app_cmd,
    output logic                app_en,
    output logic [DATA_W-1:0]   app_wdf_data,
    output logic                app_wdf_wren,
    output logic                app_wdf_end,
    output logic [DATA_W/8-1:0] app_wdf_mask,
    output logic                busy,
    output logic                done,
    output logic                tg_compare_error,
    output logic [ERR_W-1:0]    err_count,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic                rd_timeout,
    output logic [15:0]         pass_count
);
    localparam int          c_to_w      = $clog2(RD_TIMEOUT + 1);
    localparam logic [15:0] c_last_beat = 16'(BURST_NUM - 1);
    localparam logic [15:0] c_burst     = 16'(BURST_NUM);
    localparam logic [2:0]  c_cmd_wr    = 3'b000;
    localparam logic [2:0]  c_cmd_rd    = 3'b001;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WRITE   = 3'd1,
        S_READ    = 3'd2,
        S_WAIT_RD = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t              r_state, w_state_nx;
    logic [15:0]         r_cmd_idx, w_cmd_idx_nx;
    logic [15:0]         r_rx_idx, w_rx_idx_nx;
    logic [31:0]         r_pass, w_pass_nx;
    logic                r_cmd_done, w_cmd_done_nx;
    logic                r_dat_done, w_dat_done_nx;
    logic                r_first_seen, w_first_seen_nx;
    logic [c_to_w-1:0]   r_to_cnt, w_to_cnt_nx;
    logic [ADDR_W-1:0]   w_addr_nx, w_first_err_addr_nx;
    logic [2:0]          w_cmd_nx;
    logic                w_en_nx, w_wren_nx, w_cmp_err_nx, w_timeout_nx;
    logic [DATA_W-1:0]   w_wdata_nx;
    logic [ERR_W-1:0]    w_err_count_nx;
    logic [15:0]         w_pass_count_nx;

    function automatic logic [DATA_W-1:0] pattern(input logic [15:0] beat, input logic [31:0] pass);
        logic [31:0] word;
        word = SEED + 32'(beat) * 32'(DATA_INC) + pass;
        return {(DATA_W/32){word}};
    endfunction

    function automatic logic [ADDR_W-1:0] beat_addr(input logic [15:0] beat);
        return ADDR_W'(START_ADDR) + ADDR_W'(beat) * ADDR_W'(ADDR_STEP);
    endfunction

    logic w_cmd_acc, w_dat_acc, w_cmd_ok, w_dat_ok, w_go, w_busy, w_rx_live;

    assign w_cmd_acc = app_en & app_rdy;
    assign w_dat_acc = app_wdf_wren & app_wdf_rdy;
    assign w_cmd_ok  = r_cmd_done | w_cmd_acc;
    assign w_dat_ok  = r_dat_done | w_dat_acc;
    assign w_go      = start & init_calib_complete;
    assign w_busy    = (r_state == S_WRITE) || (r_state == S_READ) || (r_state == S_WAIT_RD);
    assign w_rx_live = ((r_state == S_READ) || (r_state == S_WAIT_RD)) &&
                       app_rd_data_valid && (r_rx_idx != c_burst);

    always_comb begin
        w_state_nx          = r_state;
        w_cmd_idx_nx        = r_cmd_idx;
        w_rx_idx_nx         = r_rx_idx;
        w_pass_nx           = r_pass;
        w_cmd_done_nx       = r_cmd_done;
        w_dat_done_nx       = r_dat_done;
        w_first_seen_nx     = r_first_seen;
        w_to_cnt_nx         = r_to_cnt;
        w_addr_nx           = app_addr;
        w_cmd_nx            = app_cmd;
        w_en_nx             = app_en;
        w_wren_nx           = app_wdf_wren;
        w_wdata_nx          = app_wdf_data;
        w_cmp_err_nx        = tg_compare_error;
        w_err_count_nx      = err_count;
        w_first_err_addr_nx = first_err_addr;
        w_timeout_nx        = rd_timeout;
        w_pass_count_nx     = pass_count;

        if (w_rx_live) begin
            w_rx_idx_nx = r_rx_idx + 16'd1;
            if (app_rd_data != pattern(r_rx_idx, r_pass)) begin
                w_cmp_err_nx = 1'b1;
                if (err_count != '1) begin
                    w_err_count_nx = err_count + 1'b1;
                end
                if (!r_first_seen) begin
                    w_first_seen_nx     = 1'b1;
                    w_first_err_addr_nx = beat_addr(r_rx_idx);
                end
            end
        end

        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_go) begin
                    w_state_nx          = S_WRITE;
                    w_cmd_idx_nx        = '0;
                    w_rx_idx_nx         = '0;
                    w_pass_nx           = '0;
                    w_cmd_done_nx       = 1'b0;
                    w_dat_done_nx       = 1'b0;
                    w_first_seen_nx     = 1'b0;
                    w_to_cnt_nx         = '0;
                    w_cmp_err_nx        = 1'b0;
                    w_err_count_nx      = '0;
                    w_first_err_addr_nx = '0;
                    w_timeout_nx        = 1'b0;
                    w_pass_count_nx     = '0;
                    w_en_nx             = 1'b1;
                    w_wren_nx           = 1'b1;
                    w_cmd_nx            = c_cmd_wr;
                    w_addr_nx           = beat_addr(16'd0);
                    w_wdata_nx          = pattern(16'd0, 32'd0);
                end
            end
            S_WRITE: begin
                if (w_cmd_ok && w_dat_ok) begin
                    w_cmd_done_nx = 1'b0;
                    w_dat_done_nx = 1'b0;
                    if (r_cmd_idx == c_last_beat) begin
                        w_state_nx   = S_READ;
                        w_cmd_idx_nx = '0;
                        w_en_nx      = 1'b1;
                        w_wren_nx    = 1'b0;
                        w_cmd_nx     = c_cmd_rd;
                        w_addr_nx    = beat_addr(16'd0);
                    end else begin
                        w_cmd_idx_nx = r_cmd_idx + 16'd1;
                        w_en_nx      = 1'b1;
                        w_wren_nx    = 1'b1;
                        w_addr_nx    = beat_addr(r_cmd_idx + 16'd1);
                        w_wdata_nx   = pattern(r_cmd_idx + 16'd1, r_pass);
                    end
                end else begin
                    // Hold whichever half of the beat is still outstanding.
                    w_cmd_done_nx = w_cmd_ok;
                    w_dat_done_nx = w_dat_ok;
                    w_en_nx       = ~w_cmd_ok;
                    w_wren_nx     = ~w_dat_ok;
                end
            end
            S_READ: begin
                w_to_cnt_nx = '0;
                if (w_cmd_acc) begin
                    if (r_cmd_idx == c_last_beat) begin
                        w_state_nx = S_WAIT_RD;
                        w_en_nx    = 1'b0;
                    end else begin
                        w_cmd_idx_nx = r_cmd_idx + 16'd1;
                        w_addr_nx    = beat_addr(r_cmd_idx + 16'd1);
                    end
                end
            end
            S_WAIT_RD: begin
                if (r_rx_idx == c_burst) begin
                    w_pass_count_nx = pass_count + 16'd1;
                    w_to_cnt_nx     = '0;
                    if ((LOOP != 0) && !stop) begin
                        w_state_nx   = S_WRITE;
                        w_pass_nx    = r_pass + 32'd1;
                        w_cmd_idx_nx = '0;
                        w_rx_idx_nx  = '0;
                        w_en_nx      = 1'b1;
                        w_wren_nx    = 1'b1;
                        w_cmd_nx     = c_cmd_wr;
                        w_addr_nx    = beat_addr(16'd0);
                        w_wdata_nx   = pattern(16'd0, r_pass + 32'd1);
                    end else begin
                        w_state_nx = S_DONE;
                    end
                end else if (app_rd_data_valid) begin
                    w_to_cnt_nx = '0;
                end else if (r_to_cnt == c_to_w'(RD_TIMEOUT - 1)) begin
                    w_timeout_nx = 1'b1;
                    w_state_nx   = S_DONE;
                end else begin
                    w_to_cnt_nx = r_to_cnt + 1'b1;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase

        // Losing calibration aborts the run but preserves the results so far.
        if (w_busy && !init_calib_complete) begin
            w_state_nx    = S_IDLE;
            w_en_nx       = 1'b0;
            w_wren_nx     = 1'b0;
            w_cmd_done_nx = 1'b0;
            w_dat_done_nx = 1'b0;
        end
    end

    always_ff @(posedge ui_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_state          <= S_IDLE;
            r_cmd_idx        <= '0;
            r_rx_idx         <= '0;
            r_pass           <= '0;
            r_cmd_done       <= 1'b0;
            r_dat_done       <= 1'b0;
            r_first_seen     <= 1'b0;
            r_to_cnt         <= '0;
            app_addr         <= '0;
            app_cmd          <= c_cmd_wr;
            app_en           <= 1'b0;
            app_wdf_wren     <= 1'b0;
            app_wdf_data     <= '0;
            tg_compare_error <= 1'b0;
            err_count        <= '0;
            first_err_addr   <= '0;
            rd_timeout       <= 1'b0;
            pass_count       <= '0;
        end else begin
            r_state          <= w_state_nx;
            r_cmd_idx        <= w_cmd_idx_nx;
            r_rx_idx         <= w_rx_idx_nx;
            r_pass           <= w_pass_nx;
            r_cmd_done       <= w_cmd_done_nx;
            r_dat_done       <= w_dat_done_nx;
            r_first_seen     <= w_first_seen_nx;
            r_to_cnt         <= w_to_cnt_nx;
            app_addr         <= w_addr_nx;
            app_cmd          <= w_cmd_nx;
            app_en           <= w_en_nx;
            app_wdf_wren     <= w_wren_nx;
            app_wdf_data     <= w_wdata_nx;
            tg_compare_error <= w_cmp_err_nx;
            err_count        <= w_err_count_nx;
            first_err_addr   <= w_first_err_addr_nx;
            rd_timeout       <= w_timeout_nx;
            pass_count       <= w_pass_count_nx;
        end
    end

    assign app_wdf_end  = app_wdf_wren;
    assign app_wdf_mask = '0;
    assign busy         = w_busy;
    assign done         = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_ddr_traffic_chk.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr_traffic_chk
// Brief    : Randomised bench for ddr_traffic_chk with a MIG memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr_traffic_chk;
    localparam int          ADDR_W = 29;
    localparam int          DATA_W = 256;
    localparam int          BURST  = 20;
    localparam int          ASTEP  = 8;
    localparam int          DINC   = 2;
    localparam int          TO     = 16;
    localparam logic [31:0] SEED   = 32'h0;

    logic                ui_clk = 1'b0;
    logic                sys_rst = 1'b0;
    logic                init_calib_complete = 1'b1;
    logic                start = 1'b0;
    logic                stop = 1'b1;
    logic                app_rdy = 1'b0;
    logic                app_wdf_rdy = 1'b0;
    logic [DATA_W-1:0]   app_rd_data = '0;
    logic                app_rd_data_valid = 1'b0;
    logic [ADDR_W-1:0]   app_addr;
    logic [2:0]          app_cmd;
    logic                app_en;
    logic [DATA_W-1:0]   app_wdf_data;
    logic                app_wdf_wren;
    logic                app_wdf_end;
    logic [DATA_W/8-1:0] app_wdf_mask;
    logic                busy;
    logic                done;
    logic                tg_compare_error;
    logic [15:0]         err_count;
    logic [ADDR_W-1:0]   first_err_addr;
    logic                rd_timeout;
    logic [15:0]         pass_count;

    ddr_traffic_chk #(.LOOP(1), .RD_TIMEOUT(TO), .SEED(SEED)) dut (
        .ui_clk(ui_clk), .sys_rst(sys_rst), .init_calib_complete(init_calib_complete),
        .start(start), .stop(stop), .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
        .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_wdf_mask(app_wdf_mask), .busy(busy), .done(done),
        .tg_compare_error(tg_compare_error), .err_count(err_count),
        .first_err_addr(first_err_addr), .rd_timeout(rd_timeout), .pass_count(pass_count)
    );

    always #5 ui_clk = ~ui_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge ui_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] pat(input int beat, input int pass);
        logic [31:0] w;
        w = SEED + 32'(beat * DINC) + 32'(pass);
        return {(DATA_W/32){w}};
    endfunction

    function automatic logic [ADDR_W-1:0] addr_of(input int beat);
        return ADDR_W'(beat * ASTEP);
    endfunction

    // Memory model state
    logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
    logic [ADDR_W-1:0] wcmd_q[$];
    logic [DATA_W-1:0] wdat_q[$];
    logic [ADDR_W-1:0] rd_addr_q[$];
    int                rd_rel_q[$];
    int  wc, wd, rc, rsp, last_rel, corrupt_n, hold_seen, last_valid_cyc;
    int  rdy_pct = 100, wdf_pct = 100, lat_min = 2, lat_max = 2;
    int  stall_beat = -1, stall_left = 0, drop_from = -1, corrupt_a = -1, corrupt_b = -1;
    bit  model_on = 1'b0, pend_cmd, pend_dat, cmd_acc, dat_acc;
    logic [31:0]       pass2_first;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    int                m_beat, m_rel;

    task automatic model_clear();
        mem.delete(); wcmd_q.delete(); wdat_q.delete(); rd_addr_q.delete(); rd_rel_q.delete();
        wc = 0; wd = 0; rc = 0; rsp = 0; last_rel = 0; corrupt_n = 0; hold_seen = 0;
        last_valid_cyc = 0; pend_cmd = 0; pend_dat = 0; pass2_first = '1;
        stall_beat = -1; stall_left = 0; drop_from = -1; corrupt_a = -1; corrupt_b = -1;
    endtask

    always @(negedge ui_clk) begin
        if (!sys_rst || !model_on) begin
            app_rd_data_valid = 1'b0;
            pend_cmd = 0;
            pend_dat = 0;
        end else begin
            app_rdy     = ($urandom_range(99) < 32'(rdy_pct));
            app_wdf_rdy = ($urandom_range(99) < 32'(wdf_pct));
            if (stall_beat >= 0 && app_wdf_wren && wd == stall_beat && stall_left > 0) begin
                app_wdf_rdy = 1'b0;
                stall_left--;
            end
            cmd_acc = app_en && app_rdy;
            dat_acc = app_wdf_wren && app_wdf_rdy;
            // A half-accepted write beat must keep only the pending half asserted.
            if (init_calib_complete && pend_cmd) begin
                check("hold_en_low", app_en, 0);
                check("hold_wren_high", app_wdf_wren, 1);
                hold_seen++;
            end
            if (init_calib_complete && pend_dat) begin
                check("hold_wren_low", app_wdf_wren, 0);
                check("hold_en_high", app_en, 1);
            end
            if (dat_acc) pend_cmd = 0;
            if (cmd_acc) pend_dat = 0;
            if (cmd_acc && app_wdf_wren && !app_wdf_rdy) pend_cmd = 1;
            if (dat_acc && app_en && !app_rdy) pend_dat = 1;

            if (cmd_acc && app_cmd == 3'b000) begin
                check("wr_addr", app_addr, addr_of(wc % BURST));
                wcmd_q.push_back(app_addr);
                wc++;
            end
            if (dat_acc) begin
                check("wr_data", app_wdf_data, pat(wd % BURST, wd / BURST));
                check("wdf_end", app_wdf_end, 1);
                if (wd == 2 * BURST) pass2_first = app_wdf_data[31:0];
                wdat_q.push_back(app_wdf_data);
                wd++;
            end
            while (wcmd_q.size() > 0 && wdat_q.size() > 0) begin
                m_addr = wcmd_q.pop_front();
                mem[m_addr] = wdat_q.pop_front();
            end
            if (cmd_acc && app_cmd == 3'b001) begin
                check("rd_addr", app_addr, addr_of(rc % BURST));
                rc++;
                m_rel = cyc + int'($urandom_range(lat_max, lat_min));
                if (m_rel < last_rel) m_rel = last_rel;
                last_rel = m_rel;
                rd_addr_q.push_back(app_addr);
                rd_rel_q.push_back(m_rel);
            end

            app_rd_data_valid = 1'b0;
            if (rd_rel_q.size() > 0 && rd_rel_q[0] <= cyc) begin
                m_addr = rd_addr_q.pop_front();
                void'(rd_rel_q.pop_front());
                m_beat = rsp % BURST;
                rsp++;
                if (drop_from < 0 || m_beat < drop_from) begin
                    m_data = mem.exists(m_addr) ? mem[m_addr] : '0;
                    if (m_beat == corrupt_a || m_beat == corrupt_b) begin
                        m_data[0] = ~m_data[0];
                        corrupt_n++;
                    end
                    app_rd_data       = m_data;
                    app_rd_data_valid = 1'b1;
                    last_valid_cyc    = cyc;
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge ui_clk); #1 start = 1'b1;
        @(negedge ui_clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        bit ok;
        ok = 0;
        for (int k = 0; k < max_cyc; k++) begin
            @(negedge ui_clk); #1;
            if (done) begin
                ok = 1;
                break;
            end
        end
        check({tag, "_done"}, ok, 1);
    endtask

    task automatic check_result(input string tag, input int e_flag, input int e_cnt,
                                input int e_first, input int e_to, input int e_pass);
        check({tag, "_cmp_err"}, tg_compare_error, e_flag);
        check({tag, "_err_cnt"}, err_count, e_cnt);
        check({tag, "_first"}, first_err_addr, e_first);
        check({tag, "_timeout"}, rd_timeout, e_to);
        check({tag, "_passes"}, pass_count, e_pass);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic check_mem(input string tag, input int pass);
        for (int i = 0; i < BURST; i++)
            check($sformatf("%s_mem%0d", tag, i),
                  mem.exists(addr_of(i)) ? mem[addr_of(i)] : '0, pat(i, pass));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge ui_clk);
        #1;
        check("rst_app_en", app_en, 0);
        check("rst_wren", app_wdf_wren, 0);
        check("rst_addr", app_addr, 0);
        check("rst_cmd", app_cmd, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err_count, 0);
        check("rst_passes", pass_count, 0);
        sys_rst = 1'b1;
        model_clear();
        model_on = 1'b1;

        // Single clean pass with always-ready MIG
        pulse_start();
        wait_done("basic", 1000);
        check_result("basic", 0, 0, 0, 0, 1);
        check("basic_wr_cnt", wc, BURST);
        check("basic_rd_cnt", rc, BURST);
        check_mem("basic", 0);

        // Write-data stall on beat 5 while commands keep flowing
        model_clear();
        stall_beat = 5;
        stall_left = 3;
        pulse_start();
        wait_done("stall", 1000);
        check_result("stall", 0, 0, 0, 0, 1);
        check("stall_held_cycles", hold_seen, 3);
        check_mem("stall", 0);

        // Randomised handshakes and read latency
        for (int r = 0; r < 3; r++) begin
            model_clear();
            rdy_pct = int'($urandom_range(90, 40));
            wdf_pct = int'($urandom_range(90, 40));
            lat_min = 2;
            lat_max = 6;
            pulse_start();
            wait_done("rand", 3000);
            check_result("rand", 0, 0, 0, 0, 1);
        end

        // Corrupted read beats
        model_clear();
        corrupt_a = 7;
        corrupt_b = 12;
        pulse_start();
        wait_done("corrupt", 3000);
        check_result("corrupt", 1, corrupt_n, addr_of(7), 0, 1);
        check("corrupt_model_cnt", corrupt_n, 2);

        // Missing final beat -> read timeout
        model_clear();
        rdy_pct = 100;
        wdf_pct = 100;
        lat_min = 4;
        lat_max = 4;
        drop_from = BURST - 1;
        pulse_start();
        wait_done("timeout", 1000);
        check_result("timeout", 0, 0, 0, 1, 0);
        check("timeout_latency", cyc - last_valid_cyc, TO + 1);

        // Continuous loop, stop during pass 2
        model_clear();
        rdy_pct = 75;
        wdf_pct = 75;
        lat_min = 2;
        lat_max = 5;
        stop = 1'b0;
        pulse_start();
        for (int k = 0; k < 3000 && wc < 2 * BURST + 1; k++) begin
            @(negedge ui_clk); #1;
        end
        stop = 1'b1;
        wait_done("loop", 3000);
        check_result("loop", 0, 0, 0, 0, 3);
        check("loop_pass2_first", pass2_first, 2);
        check_mem("loop", 2);

        // Calibration loss mid-write
        model_clear();
        rdy_pct = 100;
        wdf_pct = 100;
        lat_min = 2;
        lat_max = 2;
        pulse_start();
        for (int k = 0; k < 200 && wc < 11; k++) begin
            @(negedge ui_clk); #1;
        end
        check("calib_beat_addr", app_addr, addr_of(10));
        init_calib_complete = 1'b0;
        @(negedge ui_clk); #1;
        check("calib_busy", busy, 0);
        check("calib_app_en", app_en, 0);
        check("calib_wren", app_wdf_wren, 0);
        check("calib_done", done, 0);
        init_calib_complete = 1'b1;

        // Asynchronous reset mid-read
        model_clear();
        corrupt_a = 0;
        pulse_start();
        for (int k = 0; k < 300 && rsp < 3; k++) begin
            @(negedge ui_clk); #1;
        end
        check("pre_rst_cmd", app_cmd, 3'b001);
        check("pre_rst_err", err_count, 1);
        #2 sys_rst = 1'b0;
        #1;
        check("arst_app_en", app_en, 0);
        check("arst_addr", app_addr, 0);
        check("arst_cmd", app_cmd, 0);
        check("arst_busy", busy, 0);
        check("arst_err", err_count, 0);
        check("arst_cmp_err", tg_compare_error, 0);
        check("arst_first", first_err_addr, 0);
        check("arst_passes", pass_count, 0);
        repeat (2) @(negedge ui_clk);
        #1 sys_rst = 1'b1;
        model_clear();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ddr_traffic_chk.md
Name: ddr_traffic_chk

Overview:
- Parametrised DDR3 traffic generator/checker on the MIG 7-series application interface, clocked by ui_clk.
- Writes BURST_NUM beats of a deterministic pattern, reads them back and compares each returned beat.
- Reports errors, count, first failing address and read timeout.
- Supports single-pass or continuous loop mode and independent command/data handshakes; supersedes the fixed 20-beat bring-up sequencer.

Parameters:
ADDR_W, 29, app_addr width
DATA_W, 256, app data width; must be a multiple of 32
BURST_NUM, 20, beats per pass (1..2^16-1)
ADDR_STEP, 8, app_addr increment per beat
START_ADDR, 0, first beat address
SEED, 32'h0, pattern base word
DATA_INC, 2, pattern increment per beat
LOOP, 0, 0: single pass then DONE; 1: repeat passes until stop
ERR_W, 16, err_count width (saturating)
RD_TIMEOUT, 1024, max ui_clk cycles in WAIT_RD without app_rd_data_valid

Ports:
ui_clk  in  1  clock, MIG user clock
sys_rst  in  1  asynchronous active-low reset (0 = reset)
init_calib_complete  in  1  MIG calibration done
start  in  1  one-cycle start request
stop  in  1  level; in LOOP, finish current pass then DONE
app_rdy  in  1  MIG command ready
app_wdf_rdy  in  1  MIG write-data ready
app_rd_data  in  DATA_W  read data
app_rd_data_valid  in  1  read data valid
app_addr  out  ADDR_W  command address
app_cmd  out  3  3'b000 write, 3'b001 read
app_en  out  1  command valid
app_wdf_data  out  DATA_W  write data
app_wdf_wren  out  1  write data valid
app_wdf_end  out  1  equals app_wdf_wren
app_wdf_mask  out  DATA_W/8  tied 0
busy  out  1  high in WRITE/READ/WAIT_RD
done  out  1  high in DONE
tg_compare_error  out  1  sticky mismatch flag
err_count  out  ERR_W  mismatching beats, saturates at all-ones
first_err_addr  out  ADDR_W  address of first mismatching beat
rd_timeout  out  1  sticky timeout flag
pass_count  out  16  completed passes, wraps

Behaviour:
- Reset (sys_rst=0, async): state IDLE; all outputs 0; app_cmd=3'b000; counters and flags cleared.
- Pattern: beat i of pass p = 32-bit word (SEED + i*DATA_INC + p) mod 2^32, replicated DATA_W/32 times.
- Beat address: START_ADDR + i*ADDR_STEP, mod 2^ADDR_W.
- All app_* outputs are registered.
- State IDLE: on start=1 with init_calib_complete=1, go to WRITE next cycle, p=0. Start is ignored otherwise.
- State WRITE:
  - app_en=1, app_cmd=000, app_wdf_wren=1, beat i presented.
  - Command is accepted on the cycle app_en&app_rdy; app_en drops the next cycle if data is still pending.
  - Data is accepted on the cycle app_wdf_wren&app_wdf_rdy; app_wdf_wren drops the next cycle if the command is still pending.
  - Either order is legal; the beat completes when both have been accepted.
  - If both are accepted in the same cycle, beat i+1 is presented the next cycle with no bubble.
  - After beat BURST_NUM-1 completes, go to READ.
- State READ:
  - app_en=1, app_cmd=001, app_wdf_wren=0.
  - Address advances on each app_rdy.
  - After BURST_NUM read commands are accepted, go to WAIT_RD with app_en=0.
- Receive path (active in READ and WAIT_RD):
  - rx counter increments on app_rd_data_valid; the beat is compared against pattern(rx, p) in the same cycle.
  - On mismatch: tg_compare_error<=1 and err_count saturating +1. On the first mismatch since start, capture the rx beat address in first_err_addr.
  - Valid beats after rx reaches BURST_NUM, or valids in any other state, are ignored.
- State WAIT_RD:
  - Timeout counter is reset on each valid.
  - On reaching RD_TIMEOUT: rd_timeout<=1, go to DONE.
  - When rx==BURST_NUM: pass_count+1. If LOOP=1 and stop=0, go to WRITE with p+1, i=0, rx=0; otherwise go to DONE.
- State DONE: holds. start=1 with init_calib_complete=1 clears all flags, counters and pass_count, then goes to WRITE.
- init_calib_complete falling in any busy state: go to IDLE next cycle, drop app_en/app_wdf_wren, keep flags and counters.
- stop has no effect when LOOP=0.
- Simultaneous valid and timeout expiry in the same cycle: the valid wins and resets the timeout counter.

Test Plan:
- Defaults, app_rdy=app_wdf_rdy=1, loopback model returns correct data: 20 writes at addr 0,8,..,152 with data words 0,2,..,38, then 20 reads. Expect done=1, tg_compare_error=0, err_count=0, pass_count=1.
- Hold app_wdf_rdy=0 for 3 cycles on beat 5 while app_rdy=1: app_en drops after command acceptance, app_wdf_wren held, beat 6 appears only after data acceptance; memory contents still correct.
- Model corrupts beats 7 and 12: tg_compare_error=1, err_count=2, first_err_addr=56.
- Model returns only 19 beats, RD_TIMEOUT=16: rd_timeout=1, done=1 sixteen cycles after the last valid.
- LOOP=1, stop raised during pass 2: pass_count=3, pass-2 data words start at 2, then done=1.
- Drop init_calib_complete mid-WRITE at beat 10: state IDLE next cycle, app_en=0. Async sys_rst=0 mid-READ: all outputs 0 immediately.
